tpu_tile_sequencer: RTL and testbench
=====================================

# tpu_tile_sequencer

Command-driven controller that sequences one 4x4 output tile of the TPU datapath: it reads the K-deep A/B operand buffers, gates the MAC array, and writes the four 128-bit C rows back to the C buffer. It sits between the CFU command decode (`funct`/`input0`/`input1`) and the buffer/MAC strobes, replacing ad-hoc index-compare control with one explicit FSM. It reports busy/done/error status back to the CPU.

## Interface
- `ADDR_BITS`, default 16: width of all buffer indices.
- `K_MAX`, default 2048: largest legal K, equal to the A/B buffer depth.
- `RD_LAT`, default 2: cycles from `ab_rd_en` to operand valid at the MAC inputs (range 1..7).

- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: synchronous, active-high reset (despite the name).
- `cmd_valid` in 1: a command is present this cycle.
- `funct` in 3: command code.
- `input0` in 32: command operand 0.
- `input1` in 32: command operand 1 (unused, reserved).
- `rsp_valid` out 1: response strobe.
- `rsp_data` out 32: response word.
- `ab_rd_en` out 1: read A and B buffers at `ab_rd_idx`.
- `ab_rd_idx` out ADDR_BITS: operand index.
- `mac_clear` out 1: zero all 16 accumulators.
- `mac_en` out 1: accumulate this cycle.
- `c_wr_en` out 1: write one C row.
- `c_wr_idx` out ADDR_BITS: C buffer address.
- `c_row_sel` out 2: accumulator row (0..3) driven onto C data.
- `busy` out 1: tile in progress.
- `done` out 1: one-cycle pulse at tile completion.
- `err` out 1: sticky illegal-command flag.

## Operation
- Commands are accepted when `cmd_valid`=1; there is no backpressure.
- Every accepted command gives `rsp_valid`=1 for exactly one cycle, the cycle after acceptance.
- `rsp_data` = {`busy`, `err`, `done_seen`, 13'b0, `tiles_done`[15:0]}, sampled after the command takes effect.
- funct 1, SET_K: K := `input0`[15:0].
  - If K=0, K>`K_MAX`, or `busy`=1: the command is ignored and `err` is set.
- funct 6, START: latch base := `input0`[ADDR_BITS-1:0] and start a tile.
  - If `busy`=1 or K=0: the command is ignored and `err` is set.
- funct 4, ABORT: return to IDLE from any state and pulse `mac_clear` for 1 cycle.
  - `done` is not pulsed and `tiles_done` is unchanged.
  - `err` and `done_seen` are cleared.
- funct 7, STATUS: no side effect.
- Other funct values: no effect and no response.
- FSM states:
  - IDLE → CLR on START.
  - CLR, 1 cycle: `mac_clear`=1. → ISSUE.
  - ISSUE, K cycles: `ab_rd_en`=1, `ab_rd_idx` counts 0..K-1. → DRAIN.
  - DRAIN, RD_LAT cycles: no reads. → WB.
  - WB, 4 cycles: `c_wr_en`=1, `c_row_sel` counts 0..3, `c_wr_idx` = base + `c_row_sel` (wraps modulo 2^ADDR_BITS). → FIN.
  - FIN, 1 cycle: `done`=1, `tiles_done`+1 (wraps at 16 bits), `done_seen`:=1. → IDLE.
- `mac_en` = `ab_rd_en` delayed by exactly RD_LAT cycles, implemented as a shift register.
  - ABORT and reset flush the shift register, so no stray `mac_en` follows an abort.
- `busy` = 1 in every state except IDLE.

## Timing
- Reset (`rst_n`=1 at an edge):
  - All outputs are 0 and the FSM is in IDLE.
  - K, base, `tiles_done`, `done_seen`, `err` and the delay line are all 0.
  - Reset has priority over any simultaneous command.
  - Reset mid-tile aborts with no further strobes.
- START sampled at edge E0:
  - CLR occupies the cycle E0..E1.
  - The first `ab_rd_en` is in cycle E1..E2.
  - The first `mac_en` is RD_LAT cycles after the first `ab_rd_en`.
  - The last `mac_en` is the last DRAIN cycle.
  - The first `c_wr_en` is the cycle immediately after the last `mac_en`.
- `busy` stays high for 1+K+RD_LAT+4+1 cycles, including FIN.
  - `done` coincides with the last `busy` cycle.
  - A new START is legal from the next cycle.
- Simultaneous `done` (FIN) and an accepted STATUS: the response reflects the incremented `tiles_done` and `busy`=0.
- ABORT during WB: rows already written stay written and no further `c_wr_en` is issued.
- `ab_rd_idx`, `c_wr_idx` and `c_row_sel` are 0 whenever their enable is low.

## Test plan
- Reset with `cmd_valid`=1 and funct=6 → all outputs 0; next STATUS gives `rsp_data`=0.
- SET_K 3, then START base 0x0010 (RD_LAT=2):
  - `mac_clear` for 1 cycle.
  - `ab_rd_idx` 0,1,2.
  - `mac_en` for 3 cycles, starting 2 cycles after the first read.
  - `c_wr_idx` 0x10..0x13 with rows 0..3.
  - `done` on busy cycle 11.
  - STATUS then gives 0x2000_0001.
- START base 0xFFFE with K=1 → `c_wr_idx` FFFE, FFFF, 0000, 0001.
- START while busy, SET_K 0, and SET_K 2049 → each sets `err`; the tile in progress completes unchanged; `err` clears on ABORT.
- ABORT in the second ISSUE cycle with K=8 → next cycle IDLE with `mac_clear`=1; no `mac_en` or `c_wr_en` afterwards; `tiles_done` unchanged.
- Back-to-back: START accepted in the cycle after `done` → second tile runs with identical timing; `tiles_done`=2.

Source files
------------

// File: rtl/tpu_tile_sequencer.sv
// tpu_tile_sequencer
//
// Sequences one 4x4 output tile of the TPU datapath from CFU commands:
// it clears the MAC array, streams K operand reads from the A/B buffers,
// waits out the buffer read latency, writes the four C rows and signals completion.
// Commands: SET_K (1), ABORT (4), START (6), STATUS (7). Each accepted command
// gets a one-cycle response in the following cycle.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : synchronous reset, active HIGH despite the name
//   cmd_valid  : command present this cycle (no backpressure)
//   funct      : command code
//   input0     : command operand 0 (K or base address)
//   input1     : command operand 1 (reserved)
//   rsp_valid  : one-cycle response strobe
//   rsp_data   : {busy, err, done_seen, 13'b0, tiles_done[15:0]}
//   ab_rd_en   : read A/B buffers at ab_rd_idx
//   ab_rd_idx  : operand index (0 when not reading)
//   mac_clear  : zero all accumulators
//   mac_en     : accumulate this cycle (ab_rd_en delayed by RD_LAT)
//   c_wr_en    : write one C row
//   c_wr_idx   : C buffer address (0 when not writing)
//   c_row_sel  : accumulator row driven onto C data (0 when not writing)
//   busy       : tile in progress
//   done       : one-cycle pulse in the last busy cycle
//   err        : sticky illegal-command flag, cleared by ABORT

module tpu_tile_sequencer #(
    parameter int unsigned ADDR_BITS = 16,
    parameter int unsigned K_MAX     = 2048,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    input  logic [2:0]           funct,
    input  logic [31:0]          input0,
    input  logic [31:0]          input1,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_data,
    output logic                 ab_rd_en,
    output logic [ADDR_BITS-1:0] ab_rd_idx,
    output logic                 mac_clear,
    output logic                 mac_en,
    output logic                 c_wr_en,
    output logic [ADDR_BITS-1:0] c_wr_idx,
    output logic [1:0]           c_row_sel,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [2:0]  FunctSetK   = 3'd1;
    localparam logic [2:0]  FunctAbort  = 3'd4;
    localparam logic [2:0]  FunctStart  = 3'd6;
    localparam logic [2:0]  FunctStatus = 3'd7;
    localparam logic [15:0] DrainLast   = 16'(RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StIssue,
        StDrain,
        StWb,
        StFin
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;      // per-state position counter
    logic [15:0]            k_q, k_d;
    logic [ADDR_BITS-1:0]   base_q, base_d;
    logic [15:0]            tiles_q, tiles_d;
    logic                   done_seen_q, done_seen_d;
    logic                   err_q, err_d;
    logic                   abort_clr_q, abort_clr_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   flush;
    logic [RD_LAT-1:0]      rd_pipe_q;         // ab_rd_en history feeding mac_en
    logic [15:0]            k_in;

    assign k_in = input0[15:0];

    // input1 is reserved and the upper operand bits are ignored.
    logic unused_operands;
    assign unused_operands = ^{input1, input0};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        base_d      = base_q;
        tiles_d     = tiles_q;
        done_seen_d = done_seen_q;
        err_d       = err_q;
        abort_clr_d = 1'b0;
        rsp_valid_d = 1'b0;
        flush       = 1'b0;

        // Tile progression.
        case (state_q)
            StIdle: ;
            StClr: begin
                state_d = StIssue;
                cnt_d   = '0;
            end
            StIssue: begin
                if (cnt_q == k_q - 16'd1) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StDrain: begin
                if (cnt_q == DrainLast) begin
                    state_d = StWb;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWb: begin
                if (cnt_q == 16'd3) begin
                    state_d = StFin;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StFin: begin
                state_d     = StIdle;
                tiles_d     = tiles_q + 16'd1;
                done_seen_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Commands override the progression above where they conflict.
        if (cmd_valid) begin
            case (funct)
                FunctSetK: begin
                    rsp_valid_d = 1'b1;
                    if (busy || k_in == 16'd0 || {16'd0, k_in} > K_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        k_d = k_in;
                    end
                end
                FunctStart: begin
                    rsp_valid_d = 1'b1;
                    if (busy || k_q == 16'd0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StClr;
                        cnt_d   = '0;
                        base_d  = input0[ADDR_BITS-1:0];
                    end
                end
                FunctAbort: begin
                    rsp_valid_d = 1'b1;
                    state_d     = StIdle;
                    cnt_d       = '0;
                    tiles_d     = tiles_q;   // an abort in FIN does not count the tile
                    done_seen_d = 1'b0;
                    err_d       = 1'b0;
                    abort_clr_d = 1'b1;
                    flush       = 1'b1;
                end
                FunctStatus: rsp_valid_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            k_q         <= '0;
            base_q      <= '0;
            tiles_q     <= '0;
            done_seen_q <= 1'b0;
            err_q       <= 1'b0;
            abort_clr_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            base_q      <= base_d;
            tiles_q     <= tiles_d;
            done_seen_q <= done_seen_d;
            err_q       <= err_d;
            abort_clr_q <= abort_clr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Read-latency delay line; flushed so no stray accumulate follows an abort.
    always_ff @(posedge clk) begin
        if (rst_n || flush) begin
            rd_pipe_q <= '0;
        end else begin
            rd_pipe_q[0] <= ab_rd_en;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                rd_pipe_q[i] <= rd_pipe_q[i-1];
            end
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = (state_q == StFin);
        err       = err_q;
        ab_rd_en  = (state_q == StIssue);
        ab_rd_idx = ab_rd_en ? ADDR_BITS'(cnt_q) : '0;
        mac_clear = (state_q == StClr) || abort_clr_q;
        mac_en    = rd_pipe_q[RD_LAT-1];
        c_wr_en   = (state_q == StWb);
        c_row_sel = c_wr_en ? cnt_q[1:0] : 2'd0;
        c_wr_idx  = c_wr_en ? base_q + ADDR_BITS'(cnt_q[1:0]) : '0;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_valid_q ? {busy, err_q, done_seen_q, 13'b0, tiles_q} : 32'd0;
    end

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Testbench for tpu_tile_sequencer: directed scenarios plus randomized commands,
// every cycle compared against a tile-timeline reference model.

module tb_tpu_tile_sequencer;

    localparam int unsigned ADDR_BITS = 16;
    localparam int unsigned K_MAX     = 2048;
    localparam int unsigned RD_LAT    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 cmd_valid = 1'b0;
    logic [2:0]           funct = 3'd0;
    logic [31:0]          input0 = 32'd0;
    logic [31:0]          input1 = 32'd0;
    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic                 ab_rd_en;
    logic [ADDR_BITS-1:0] ab_rd_idx;
    logic                 mac_clear;
    logic                 mac_en;
    logic                 c_wr_en;
    logic [ADDR_BITS-1:0] c_wr_idx;
    logic [1:0]           c_row_sel;
    logic                 busy;
    logic                 done;
    logic                 err;

    tpu_tile_sequencer #(
        .ADDR_BITS (ADDR_BITS),
        .K_MAX     (K_MAX),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .funct     (funct),
        .input0    (input0),
        .input1    (input1),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .ab_rd_en  (ab_rd_en),
        .ab_rd_idx (ab_rd_idx),
        .mac_clear (mac_clear),
        .mac_en    (mac_en),
        .c_wr_en   (c_wr_en),
        .c_wr_idx  (c_wr_idx),
        .c_row_sel (c_row_sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a tile is a timeline indexed by t = cycles since START
    // was accepted (t=0 is the clear cycle).
    bit          m_active;
    int unsigned m_t;
    int unsigned m_k;
    int unsigned m_base;
    int unsigned m_tiles;
    bit          m_done_seen;
    bit          m_err;
    bit          m_clr_pend;
    bit          m_rsp;

    logic [15:0] wr_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned tile_len();
        return m_k + RD_LAT + 6;
    endfunction

    task automatic model_step(input bit rst, input bit cv, input logic [2:0] f,
                              input logic [31:0] in0);
        int unsigned tiles_before;
        bit          was_busy;
        bit          fin_now;
        int unsigned kin;
        if (rst) begin
            m_active = 0; m_t = 0; m_k = 0; m_base = 0; m_tiles = 0;
            m_done_seen = 0; m_err = 0; m_clr_pend = 0; m_rsp = 0;
            return;
        end
        tiles_before = m_tiles;
        was_busy     = m_active;
        fin_now      = m_active && (m_t == tile_len() - 1);
        m_clr_pend   = 0;
        m_rsp        = 0;
        if (m_active) begin
            if (fin_now) begin
                m_active    = 0;
                m_tiles     = (m_tiles + 1) % 65536;
                m_done_seen = 1;
            end else begin
                m_t++;
            end
        end
        if (cv) begin
            case (f)
                3'd1: begin
                    m_rsp = 1;
                    kin = int'(in0[15:0]);
                    if (was_busy || kin == 0 || kin > K_MAX) m_err = 1;
                    else m_k = kin;
                end
                3'd6: begin
                    m_rsp = 1;
                    if (was_busy || m_k == 0) m_err = 1;
                    else begin
                        m_active = 1;
                        m_t      = 0;
                        m_base   = int'(in0[15:0]);
                    end
                end
                3'd4: begin
                    m_rsp       = 1;
                    m_active    = 0;
                    m_clr_pend  = 1;
                    m_err       = 0;
                    m_done_seen = 0;
                    m_tiles     = tiles_before;
                end
                3'd7: m_rsp = 1;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        int unsigned t     = m_t;
        bit          a     = m_active;
        int unsigned wb0   = m_k + RD_LAT + 1;
        bit          e_rd  = a && t >= 1 && t <= m_k;
        bit          e_mac = a && t >= 1 + RD_LAT && t <= m_k + RD_LAT;
        bit          e_wr  = a && t >= wb0 && t <= wb0 + 3;
        int unsigned row   = e_wr ? t - wb0 : 0;
        logic [15:0] e_tiles = 16'(m_tiles);
        check_eq("busy", busy, a);
        check_eq("done", done, a && t == tile_len() - 1);
        check_eq("mac_clear", mac_clear, (a && t == 0) || m_clr_pend);
        check_eq("ab_rd_en", ab_rd_en, e_rd);
        check_eq("ab_rd_idx", ab_rd_idx, e_rd ? t - 1 : 0);
        check_eq("mac_en", mac_en, e_mac);
        check_eq("c_wr_en", c_wr_en, e_wr);
        check_eq("c_row_sel", c_row_sel, row);
        check_eq("c_wr_idx", c_wr_idx, e_wr ? (m_base + row) % 65536 : 0);
        check_eq("err", err, m_err);
        check_eq("rsp_valid", rsp_valid, m_rsp);
        if (m_rsp)
            check_eq("rsp_data", rsp_data, {a, m_err, m_done_seen, 13'b0, e_tiles});
        if (c_wr_en) wr_log.push_back(c_wr_idx);
    endtask

    task automatic step(input bit rst, input bit cv, input logic [2:0] f, input logic [31:0] in0);
        @(negedge clk);
        rst_n     = rst;
        cmd_valid = cv;
        funct     = f;
        input0    = in0;
        input1    = $urandom;
        @(posedge clk);
        model_step(rst, cv, f, in0);
        #1;
        check_outputs();
    endtask

    task automatic cmd(input logic [2:0] f, input logic [31:0] in0);
        step(1'b0, 1'b1, f, in0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom), $urandom);
    endtask

    task automatic check_log(input string tag, input logic [15:0] first);
        logic [15:0] exp;
        check_eq({tag, "_count"}, wr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            exp = first + 16'(i);
            check_eq(tag, (wr_log.size() > i) ? wr_log[i] : 16'hDEAD, exp);
        end
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        int strays;
        bit seen_done;
        int r;
        logic [2:0] uf;
        logic [31:0] kv;

        // Reset wins over a simultaneous START.
        step(1'b1, 1'b1, 3'd6, 32'h10);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_mac_clear", mac_clear, 0);
        cmd(3'd7, 32'h0);
        check_eq("reset_status", rsp_data, 32'h0);

        // Basic tile: K=3, base 0x10.
        cmd(3'd1, 32'h3);
        wr_log.delete();
        cmd(3'd6, 32'h10);
        check_eq("basic_clr", mac_clear, 1);
        busy_cnt = 1;
        done_at  = 0;
        for (int i = 0; i < 14; i++) begin
            idle(1);
            if (busy) busy_cnt++;
            if (done) done_at = busy_cnt;
        end
        check_eq("basic_busy_len", busy_cnt, 11);
        check_eq("basic_done_at", done_at, 11);
        check_log("basic_wr_idx", 16'h0010);
        cmd(3'd7, 32'h0);
        check_eq("basic_status", rsp_data, 32'h2000_0001);

        // Address wrap: K=1, base 0xFFFE.
        cmd(3'd1, 32'h1);
        wr_log.delete();
        cmd(3'd6, 32'hFFFE);
        idle(12);
        check_log("wrap_wr_idx", 16'hFFFE);

        // Illegal commands during a tile.
        cmd(3'd1, 32'h5);
        wr_log.delete();
        cmd(3'd6, 32'h100);
        idle(2);
        cmd(3'd6, 32'h200);
        check_eq("err_start_busy", err, 1);
        cmd(3'd1, 32'h0);
        cmd(3'd1, 32'd2049);
        idle(15);
        check_log("err_tile_wr_idx", 16'h0100);
        check_eq("err_sticky", err, 1);
        cmd(3'd4, 32'h0);
        check_eq("err_cleared", err, 0);
        check_eq("abort_idle_clr", mac_clear, 1);

        // K_MAX boundary while idle.
        cmd(3'd1, 32'd2048);
        check_eq("kmax_ok", err, 0);
        cmd(3'd1, 32'hABCD_0801);
        check_eq("kmax_plus1", err, 1);
        cmd(3'd4, 32'h0);

        // Abort in the second ISSUE cycle, K=8.
        cmd(3'd1, 32'h8);
        cmd(3'd6, 32'h40);
        idle(2);
        check_eq("abort_pre_idx", ab_rd_idx, 1);
        cmd(3'd4, 32'h0);
        check_eq("abort_idle", busy, 0);
        check_eq("abort_clr", mac_clear, 1);
        strays = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (mac_en || c_wr_en) strays++;
        end
        check_eq("abort_strays", strays, 0);
        cmd(3'd7, 32'h0);
        check_eq("abort_status", rsp_data, 32'h0000_0003);

        // Back-to-back tiles.
        cmd(3'd1, 32'h3);
        cmd(3'd6, 32'h20);
        seen_done = 0;
        for (int i = 0; i < 20 && !seen_done; i++) begin
            idle(1);
            if (done) seen_done = 1;
        end
        check_eq("b2b_first_done", seen_done, 1);
        idle(1);
        wr_log.delete();
        cmd(3'd6, 32'h30);
        check_eq("b2b_start_ok", err, 0);
        busy_cnt = 1;
        for (int i = 0; i < 14; i++) begin
            idle(1);
            if (busy) busy_cnt++;
        end
        check_eq("b2b_busy_len", busy_cnt, 11);
        check_log("b2b_wr_idx", 16'h0030);
        cmd(3'd7, 32'h0);
        check_eq("b2b_status", rsp_data, 32'h2000_0005);

        // Randomized command stream.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 1) begin
                step(1'b1, $urandom_range(0, 1) == 1, 3'($urandom), $urandom);
            end else if (r < 4) begin
                case ($urandom_range(0, 9))
                    0: kv = 32'd0;
                    1: kv = 32'd2049;
                    default: kv = 32'($urandom_range(1, 9));
                endcase
                cmd(3'd1, ($urandom & 32'hFFFF_0000) | kv);
            end else if (r < 12) begin
                cmd(3'd6, $urandom);
            end else if (r < 13) begin
                cmd(3'd4, $urandom);
            end else if (r < 18) begin
                cmd(3'd7, $urandom);
            end else if (r < 20) begin
                case ($urandom_range(0, 3))
                    0: uf = 3'd0;
                    1: uf = 3'd2;
                    2: uf = 3'd3;
                    default: uf = 3'd5;
                endcase
                cmd(uf, $urandom);
            end else begin
                idle(1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
